memoria_microprocesador: RTL

Memory/responder end of the Microprocesador bus. It returns instruction words for Direccion_Instrucciones and serves data reads and writes on Direccion_Datos/RW.
It holds a program ROM-style array, loaded through a valid/ready load port while the processor is held in reset, plus a data RAM.
Sits beside Microprocesador at the top level and replaces the testbench-driven Instrucciones/Datos_Entrada.

---
 rtl/memoria_microprocesador_if.sv | 45 ++++
 rtl/memoria_microprocesador.sv | 118 +++++++++++
 2 files changed

// File: rtl/memoria_microprocesador_if.sv
// Bus between Microprocesador (plus its program loader) and memoria_microprocesador.
// MAPEO_ES_EN adds the memory-mapped Puerto_Salida output register.
interface memoria_microprocesador_if #(
    parameter int ANCHO_INST  = 9,
    parameter int ANCHO_DATOS = 8,
    parameter int ANCHO_DIR   = 8
);
    logic [ANCHO_DIR-1:0]   Direccion_Instrucciones;
    logic [ANCHO_INST-1:0]  Instrucciones;
    logic [ANCHO_DIR-1:0]   Direccion_Datos;
    logic [ANCHO_DATOS-1:0] Salida_Datos;
    logic                   RW;
    logic [ANCHO_DATOS-1:0] Datos_Entrada;
    logic [ANCHO_INST-1:0]  Carga_Dato;
    logic                   Carga_Valido;
    logic                   Carga_Fin;
    logic                   Carga_Listo;
    logic                   Rst_CPU;
    logic [ANCHO_DIR:0]     Longitud;
`ifdef MAPEO_ES_EN
    logic [ANCHO_DATOS-1:0] Puerto_Salida;

    modport master (
        output Direccion_Instrucciones, Direccion_Datos, Salida_Datos, RW,
               Carga_Dato, Carga_Valido, Carga_Fin,
        input  Instrucciones, Datos_Entrada, Carga_Listo, Rst_CPU, Longitud, Puerto_Salida
    );
    modport slave (
        input  Direccion_Instrucciones, Direccion_Datos, Salida_Datos, RW,
               Carga_Dato, Carga_Valido, Carga_Fin,
        output Instrucciones, Datos_Entrada, Carga_Listo, Rst_CPU, Longitud, Puerto_Salida
    );
`else
    modport master (
        output Direccion_Instrucciones, Direccion_Datos, Salida_Datos, RW,
               Carga_Dato, Carga_Valido, Carga_Fin,
        input  Instrucciones, Datos_Entrada, Carga_Listo, Rst_CPU, Longitud
    );
    modport slave (
        input  Direccion_Instrucciones, Direccion_Datos, Salida_Datos, RW,
               Carga_Dato, Carga_Valido, Carga_Fin,
        output Instrucciones, Datos_Entrada, Carga_Listo, Rst_CPU, Longitud
    );
`endif
endinterface

// File: rtl/memoria_microprocesador.sv
// Program memory (loaded while the CPU is held in reset) plus data RAM for Microprocesador.
// Define MAPEO_ES_EN to map data address all-ones onto the Puerto_Salida register.
module memoria_microprocesador #(
    parameter int ANCHO_INST  = 9,
    parameter int ANCHO_DATOS = 8,
    parameter int ANCHO_DIR   = 8,
    parameter int PROFUNDIDAD = 256
) (
    input logic Clk,
    input logic Rst,
    memoria_microprocesador_if.slave bus
);
    typedef enum logic [1:0] {REPOSO, CARGA, EJECUCION} estado_t;

    localparam logic [ANCHO_DIR:0] LLENO = (ANCHO_DIR+1)'(PROFUNDIDAD);

    estado_t                estado_q, estado_d;
    // Longitud doubles as the load pointer: both start at 0 and advance together.
    logic [ANCHO_DIR:0]     long_q, long_d;
    logic                   listo_q, listo_d;
    logic                   rst_cpu_q, rst_cpu_d;
    logic [ANCHO_INST-1:0]  inst_q, inst_d;
    logic [ANCHO_DATOS-1:0] dato_q, dato_d;
    logic [ANCHO_INST-1:0]  rom [PROFUNDIDAD];
    logic [ANCHO_DATOS-1:0] ram [PROFUNDIDAD];
    logic                   acepta, ram_we, es_io;

`ifdef MAPEO_ES_EN
    logic [ANCHO_DATOS-1:0] puerto_q, puerto_d;
`endif

    always_comb begin
        estado_d = estado_q;
        long_d   = long_q;
        acepta   = bus.Carga_Valido && listo_q;
        case (estado_q)
            REPOSO: begin
                if (acepta) begin
                    long_d   = long_q + 1'b1;
                    estado_d = bus.Carga_Fin ? EJECUCION : CARGA;
                end
            end
            CARGA: begin
                if (acepta) long_d = long_q + 1'b1;
                if (bus.Carga_Fin) estado_d = EJECUCION;
            end
            default: ;
        endcase
        rst_cpu_d = (estado_d != EJECUCION);
        listo_d   = (estado_d != EJECUCION) && (long_d != LLENO);

        inst_d = '0;
        if (estado_q == EJECUCION && {1'b0, bus.Direccion_Instrucciones} < long_q)
            inst_d = rom[bus.Direccion_Instrucciones];

`ifdef MAPEO_ES_EN
        es_io    = &bus.Direccion_Datos;
        puerto_d = puerto_q;
`else
        es_io    = 1'b0;
`endif
        dato_d = '0;
        ram_we = 1'b0;
        if (estado_q == EJECUCION) begin
            if (bus.RW) begin
                dato_d = bus.Salida_Datos;
`ifdef MAPEO_ES_EN
                if (es_io) puerto_d = bus.Salida_Datos;
`endif
                ram_we = !es_io;
            end else begin
`ifdef MAPEO_ES_EN
                dato_d = es_io ? puerto_q : ram[bus.Direccion_Datos];
`else
                dato_d = ram[bus.Direccion_Datos];
`endif
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            estado_q  <= REPOSO;
            long_q    <= '0;
            listo_q   <= 1'b0;
            rst_cpu_q <= 1'b1;
            inst_q    <= '0;
            dato_q    <= '0;
        end else begin
            estado_q  <= estado_d;
            long_q    <= long_d;
            listo_q   <= listo_d;
            rst_cpu_q <= rst_cpu_d;
            inst_q    <= inst_d;
            dato_q    <= dato_d;
        end
    end

`ifdef MAPEO_ES_EN
    always_ff @(posedge Clk) begin
        if (Rst) puerto_q <= '0;
        else     puerto_q <= puerto_d;
    end
    assign bus.Puerto_Salida = puerto_q;
`endif

    // Memory arrays survive reset; a reset cycle never writes them.
    always_ff @(posedge Clk) begin
        if (!Rst && acepta) rom[long_q[ANCHO_DIR-1:0]] <= bus.Carga_Dato;
        if (!Rst && ram_we) ram[bus.Direccion_Datos] <= bus.Salida_Datos;
    end

    assign bus.Instrucciones = inst_q;
    assign bus.Datos_Entrada = dato_q;
    assign bus.Carga_Listo   = listo_q;
    assign bus.Rst_CPU       = rst_cpu_q;
    assign bus.Longitud      = long_q;
endmodule
